tsu_q_drain: RTL and testbench



---
 rtl/tsu_pkg.sv | 30 +++
 rtl/tsu_q_obuf.sv | 53 +++++
 rtl/tsu_q_drain.sv | 106 ++++++++++
 tb/tb_tsu_q_drain.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsu_pkg.sv
// Shared record layout, FSM encoding and record unpack helper for the tsu queue drain path.
package tsu_pkg;

  localparam int TS_LSB    = 20;
  localparam int TS_W      = 36;
  localparam int MSGID_LSB = 16;
  localparam int MSGID_W   = 4;
  localparam int SEQID_W   = 16;
  localparam int RAW_W     = TS_W + MSGID_W + SEQID_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_POP    = 2'd1;
  localparam logic [1:0] ST_CAP    = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [MSGID_W-1:0] msgid;
    logic [SEQID_W-1:0] seqid;
  } tsu_rec_t;

  function automatic tsu_rec_t tsu_unpack(input logic [RAW_W-1:0] raw);
    tsu_rec_t r;
    r.ts    = raw[TS_LSB +: TS_W];
    r.msgid = raw[MSGID_LSB +: MSGID_W];
    r.seqid = raw[SEQID_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/tsu_q_obuf.sv
// Two-entry first-word-fall-through record buffer; ent0 is always the head.
// The head register keeps its last contents when the buffer drains empty.
module tsu_q_obuf
  import tsu_pkg::*;
(
  input  logic     q_rd_clk,
  input  logic     rst,
  input  logic     push,
  input  tsu_rec_t push_rec,
  input  logic     pop,
  output tsu_rec_t head,
  output logic [1:0] level
);

  tsu_rec_t   ent0;
  tsu_rec_t   ent1;
  logic [1:0] lvl;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop && (lvl != 2'd0);
  assign do_push = push && ((lvl != 2'd2) || do_pop);

  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      lvl  <= 2'd0;
    end else begin
      case (lvl)
        2'd0: begin
          if (do_push) ent0 <= push_rec;
        end
        2'd1: begin
          // push with pop at level 1: the new record replaces the head directly
          if (do_push && do_pop) ent0 <= push_rec;
          else if (do_push)      ent1 <= push_rec;
        end
        default: begin
          if (do_pop) begin
            ent0 <= ent1;
            if (do_push) ent1 <= push_rec;
          end
        end
      endcase
      lvl <= lvl + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = ent0;
  assign level = lvl;

endmodule

// File: rtl/tsu_q_drain.sv
// Drains the tsu timestamp queue, screens records by msgId mask and buffers accepted ones.
// Optional drop counter enabled by defining TSU_Q_DRAIN_DROP_CNT_EN.
//
// state  | meaning
// IDLE   | wait for queue non-empty and buffer space
// POP    | q_rd_en strobe to tsu queue
// CAP    | capture q_rd_data and evaluate filt_mask
// SETTLE | push accepted record or count drop
module tsu_q_drain
  import tsu_pkg::*;
#(
  parameter int STAT_W     = 8,
  parameter int REC_W      = 56,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              q_rd_clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] q_rd_stat,
  input  logic [REC_W-1:0]  q_rd_data,
  output logic              q_rd_en,
  input  logic [15:0]       filt_mask,
  output logic              ts_valid,
  output logic [35:0]       ts_time,
  output logic [3:0]        ts_msgid,
  output logic [15:0]       ts_seqid,
  input  logic              ts_ack,
  output logic [1:0]        ts_level,
  input  logic              drop_clr,
  output logic [15:0]       drop_cnt
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  tsu_rec_t   rd_rec;
  tsu_rec_t   cap_rec;
  logic       cap_acc;
  logic       has_space;
  logic       push;
  logic       drop;
  tsu_rec_t   head;

  assign rd_rec    = tsu_unpack(q_rd_data);
  // space is only checked here; levels can only fall until SETTLE, so it stays reserved
  assign has_space = (ts_level != 2'(OBUF_DEPTH));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if ((q_rd_stat != '0) && has_space) state_nxt = ST_POP;
      ST_POP:    state_nxt = ST_CAP;
      ST_CAP:    state_nxt = ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cap_rec <= '0;
      cap_acc <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CAP) begin
        cap_rec <= rd_rec;
        cap_acc <= filt_mask[rd_rec.msgid];
      end
    end
  end

  assign q_rd_en = (state == ST_POP);
  assign push    = (state == ST_SETTLE) && cap_acc;
  assign drop    = (state == ST_SETTLE) && !cap_acc;

  tsu_q_obuf u_obuf (
    .q_rd_clk (q_rd_clk),
    .rst      (rst),
    .push     (push),
    .push_rec (cap_rec),
    .pop      (ts_ack),
    .head     (head),
    .level    (ts_level)
  );

  assign ts_valid = (ts_level != 2'd0);
  assign ts_time  = head.ts;
  assign ts_msgid = head.msgid;
  assign ts_seqid = head.seqid;

`ifdef TSU_Q_DRAIN_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge q_rd_clk or posedge rst) begin
    if (rst)                              drop_q <= 16'h0000;
    else if (drop_clr)                    drop_q <= 16'h0000;
    else if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'h0001;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_drop;

  assign unused_drop = drop_clr ^ drop;
  assign drop_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_tsu_q_drain.sv
// Directed bench for tsu_q_drain with a behavioural tsu queue model.
module tb_tsu_q_drain;

  logic        q_rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  q_rd_stat = 8'h00;
  logic [55:0] q_rd_data = 56'h0;
  logic        q_rd_en;
  logic [15:0] filt_mask = 16'h0000;
  logic        ts_valid;
  logic [35:0] ts_time;
  logic [3:0]  ts_msgid;
  logic [15:0] ts_seqid;
  logic        ts_ack = 1'b0;
  logic [1:0]  ts_level;
  logic        drop_clr = 1'b0;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [55:0] tsu_q[$];
  int  pop_cnt = 0;
  int  run_len = 0;
  int  max_run = 0;
  int  pop_empty_err = 0;
  bit  m_popped;

  tsu_q_drain dut (
    .q_rd_clk  (q_rd_clk),
    .rst       (rst),
    .q_rd_stat (q_rd_stat),
    .q_rd_data (q_rd_data),
    .q_rd_en   (q_rd_en),
    .filt_mask (filt_mask),
    .ts_valid  (ts_valid),
    .ts_time   (ts_time),
    .ts_msgid  (ts_msgid),
    .ts_seqid  (ts_seqid),
    .ts_ack    (ts_ack),
    .ts_level  (ts_level),
    .drop_clr  (drop_clr),
    .drop_cnt  (drop_cnt)
  );

  initial forever #5 q_rd_clk = ~q_rd_clk;

  // tsu queue: data and fill level follow a pop one cycle later
  initial forever begin
    @(posedge q_rd_clk);
    m_popped = q_rd_en;
    if (m_popped) begin
      pop_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (q_rd_stat == 8'h00 || tsu_q.size() == 0) pop_empty_err++;
    end else begin
      run_len = 0;
    end
    #1;
    if (m_popped && tsu_q.size() != 0) q_rd_data = tsu_q.pop_front();
    q_rd_stat = (tsu_q.size() > 255) ? 8'hFF : 8'(tsu_q.size());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge q_rd_clk);
  endtask

  task automatic ack_one();
    ts_ack = 1'b1;
    @(negedge q_rd_clk);
    ts_ack = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      @(negedge q_rd_clk);
      n++;
      if (ts_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_pop(input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < max_cyc) begin
      @(negedge q_rd_clk);
      n++;
      if (q_rd_en) ok = 1'b1;
    end
  endtask

  function automatic logic [55:0] mkrec(input logic [35:0] ts, input logic [3:0] id, input logic [15:0] sq);
    return {ts, id, sq};
  endfunction

  typedef struct packed {
    logic [35:0] ts;
    logic [3:0]  msgid;
    logic [15:0] seqid;
    logic [15:0] mask;
    logic        acc;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  initial begin
    bit ok;
    int p0;
    int got;
    int guard;
    int exp_drop;
    logic [35:0] last_ts;

    vec[0] = '{ts: 36'hA_BCDE_F012, msgid: 4'd5,  seqid: 16'h1111, mask: 16'h0020, acc: 1'b1};
    vec[1] = '{ts: 36'hF_FFFF_FFFF, msgid: 4'd15, seqid: 16'hFFFF, mask: 16'h8000, acc: 1'b1};
    vec[2] = '{ts: 36'h0_0000_0001, msgid: 4'd15, seqid: 16'h0002, mask: 16'h7FFF, acc: 1'b0};
    vec[3] = '{ts: 36'h1_2345_6789, msgid: 4'd0,  seqid: 16'h0003, mask: 16'hFFFE, acc: 1'b0};
    vec[4] = '{ts: 36'h0_0000_0000, msgid: 4'd9,  seqid: 16'h0000, mask: 16'hFFFF, acc: 1'b1};
    vec[5] = '{ts: 36'h5_5555_5555, msgid: 4'd10, seqid: 16'hAAAA, mask: 16'h0000, acc: 1'b0};
    exp_drop = 0;

    rst = 1'b1;
    cyc(2);
    chk("rst_q_rd_en", q_rd_en, 0);
    chk("rst_ts_valid", ts_valid, 0);
    chk("rst_ts_level", ts_level, 0);
    chk("rst_ts_time", ts_time, 0);
    chk("rst_ts_msgid", ts_msgid, 0);
    chk("rst_ts_seqid", ts_seqid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    p0 = pop_cnt;
    cyc(100);
    chk("empty_pops", pop_cnt - p0, 0);
    chk("empty_valid", ts_valid, 0);

    filt_mask = 16'h0001;
    p0 = pop_cnt;
    max_run = 0;
    tsu_q.push_back(mkrec(36'h0_1234_5678, 4'h0, 16'h0007));
    wait_valid(20, ok);
    chk("single_timeout", ok, 1);
    cyc(4);
    chk("single_pops", pop_cnt - p0, 1);
    chk("single_pulse_width", max_run, 1);
    chk("single_ts_time", ts_time, 36'h0_1234_5678);
    chk("single_ts_msgid", ts_msgid, 0);
    chk("single_ts_seqid", ts_seqid, 16'h0007);
    chk("single_level", ts_level, 1);
    ack_one();
    chk("single_ack_valid", ts_valid, 0);
    chk("single_ack_level", ts_level, 0);
    chk("single_hold_time", ts_time, 36'h0_1234_5678);
    last_ts = 36'h0_1234_5678;

    for (int i = 0; i < NV; i++) begin
      filt_mask = vec[i].mask;
      tsu_q.push_back(mkrec(vec[i].ts, vec[i].msgid, vec[i].seqid));
      cyc(10);
      chk($sformatf("vec%0d_valid", i), ts_valid, vec[i].acc);
      if (vec[i].acc) begin
        chk($sformatf("vec%0d_time", i), ts_time, vec[i].ts);
        chk($sformatf("vec%0d_msgid", i), ts_msgid, vec[i].msgid);
        chk($sformatf("vec%0d_seqid", i), ts_seqid, vec[i].seqid);
        last_ts = vec[i].ts;
        ack_one();
      end else begin
        chk($sformatf("vec%0d_hold", i), ts_time, last_ts);
`ifdef TSU_Q_DRAIN_DROP_CNT_EN
        exp_drop++;
`endif
      end
    end
    chk("table_drop_cnt", drop_cnt, exp_drop);

    filt_mask = 16'h0001;
    tsu_q.push_back(mkrec(36'h0_0000_0100, 4'd0, 16'h0100));
    tsu_q.push_back(mkrec(36'h0_0000_0101, 4'd3, 16'h0101));
    tsu_q.push_back(mkrec(36'h0_0000_0102, 4'd0, 16'h0102));
    for (int k = 0; k < 2; k++) begin
      wait_valid(30, ok);
      chk($sformatf("filt%0d_timeout", k), ok, 1);
      chk($sformatf("filt%0d_seqid", k), ts_seqid, (k == 0) ? 16'h0100 : 16'h0102);
      ack_one();
    end
    cyc(10);
    chk("filt_no_extra", ts_valid, 0);
`ifdef TSU_Q_DRAIN_DROP_CNT_EN
    exp_drop++;
`endif
    chk("filt_drop_cnt", drop_cnt, exp_drop);

    drop_clr = 1'b1;
    cyc(1);
    chk("drop_clr", drop_cnt, 0);
    tsu_q.push_back(mkrec(36'h0_0000_0110, 4'd4, 16'h0110));
    cyc(10);
    chk("drop_clr_wins", drop_cnt, 0);
    drop_clr = 1'b0;
    exp_drop = 0;
    tsu_q.push_back(mkrec(36'h0_0000_0111, 4'd4, 16'h0111));
    cyc(10);
`ifdef TSU_Q_DRAIN_DROP_CNT_EN
    exp_drop = 1;
`endif
    chk("drop_after_clr", drop_cnt, exp_drop);

    filt_mask = 16'hFFFF;
    p0 = pop_cnt;
    for (int k = 0; k < 5; k++)
      tsu_q.push_back(mkrec(36'h0_0000_0200 + 36'(k), 4'(k), 16'h0200 + 16'(k)));
    cyc(40);
    chk("bp_pops", pop_cnt - p0, 2);
    chk("bp_level", ts_level, 2);
    chk("bp_head", ts_seqid, 16'h0200);
    ack_one();
    cyc(20);
    chk("bp_pops_after_ack", pop_cnt - p0, 3);
    chk("bp_level_after_ack", ts_level, 2);
    chk("bp_head_after_ack", ts_seqid, 16'h0201);
    ts_ack = 1'b1;
    got = 0;
    guard = 0;
    while (got < 4 && guard < 100) begin
      if (ts_valid) begin
        chk($sformatf("bp_drain%0d", got), ts_seqid, 16'h0201 + 16'(got));
        got++;
      end
      @(negedge q_rd_clk);
      guard++;
    end
    ts_ack = 1'b0;
    chk("bp_drain_count", got, 4);
    cyc(10);
    chk("bp_final_valid", ts_valid, 0);
    chk("bp_total_pops", pop_cnt - p0, 5);

    tsu_q.push_back(mkrec(36'h0_0000_0300, 4'd1, 16'h0300));
    wait_valid(20, ok);
    chk("sim_a_timeout", ok, 1);
    tsu_q.push_back(mkrec(36'h0_0000_0301, 4'd2, 16'h0301));
    wait_pop(20, ok);
    chk("sim_pop_timeout", ok, 1);
    cyc(2);
    chk("sim_pre_level", ts_level, 1);
    ts_ack = 1'b1;
    @(negedge q_rd_clk);
    ts_ack = 1'b0;
    chk("sim_level", ts_level, 1);
    chk("sim_valid", ts_valid, 1);
    chk("sim_head", ts_seqid, 16'h0301);
    ack_one();
    chk("sim_drained", ts_valid, 0);

    tsu_q.push_back(mkrec(36'h0_0000_0400, 4'd1, 16'h0400));
    wait_valid(20, ok);
    chk("rstop_c_timeout", ok, 1);
    tsu_q.push_back(mkrec(36'h0_0000_0401, 4'd1, 16'h0401));
    wait_pop(20, ok);
    chk("rstop_pop_timeout", ok, 1);
    cyc(1);
    rst = 1'b1;
    #1;
    chk("rstop_q_rd_en", q_rd_en, 0);
    chk("rstop_valid", ts_valid, 0);
    chk("rstop_level", ts_level, 0);
    chk("rstop_time", ts_time, 0);
    chk("rstop_msgid", ts_msgid, 0);
    chk("rstop_seqid", ts_seqid, 0);
    chk("rstop_drop_cnt", drop_cnt, 0);
    cyc(2);
    rst = 1'b0;
    tsu_q.push_back(mkrec(36'h0_0000_0402, 4'd1, 16'h0402));
    wait_valid(20, ok);
    chk("rstop_restart_timeout", ok, 1);
    chk("rstop_restart_seqid", ts_seqid, 16'h0402);
    chk("rstop_restart_level", ts_level, 1);
    ack_one();

    chk("pop_on_empty", pop_empty_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
